pipe_scroll: RTL and testbench

PIPE_SCROLL -- requirements
Module: pipe_scroll

---
 rtl/pipe_scroll.sv | 96 +++++++++
 tb/tb_pipe_scroll.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_scroll.sv
// Scrolling 16-column pipe field with bird collision detection and a saturating BCD score.
// Columns enter at 15 and shift toward 0 once every TICK_MAX+1 cycles unless a loss has frozen the field.
module pipe_scroll #(
    parameter int TICK_MAX = 2559,
    parameter int BIRD_COL = 2,
    parameter int GAP      = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         lossIn,
    input  logic [7:0]   newCol,
    input  logic [7:0]   birdRow,
    output logic [127:0] grid,
    output logic [7:0]   right,
    output logic [7:0]   mid,
    output logic         tick,
    output logic         lossOut,
    output logic [3:0]   scoreTens,
    output logic [3:0]   scoreOnes
);

    localparam logic [11:0] TICK_LAST = 12'(TICK_MAX);
    localparam logic [2:0]  GAP_LOAD  = 3'(GAP);

    logic [11:0] cnt;
    logic [2:0]  sp;
    logic [7:0]  bird_col;
    logic        frozen;
    logic        scroll;
    logic        hit;
    logic        score_en;

    // BCD +1 that sticks at 99 rather than wrapping.
    function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        res = {tens, ones};
        if (tens == 4'd9 && ones == 4'd9)
            res = {tens, ones};
        else if (ones == 4'd9)
            res = {tens + 4'd1, 4'd0};
        else
            res = {tens, ones + 4'd1};
        return res;
    endfunction

    assign bird_col = grid[8*BIRD_COL +: 8];
    assign hit      = |(bird_col & birdRow);
    assign frozen   = lossOut | lossIn;
    assign scroll   = !frozen && (cnt == TICK_LAST);
    // A pipe only scores when it is leaving the bird column cleanly on this scroll.
    assign score_en = scroll && (bird_col != 8'h00) && !hit;

    assign right = grid[127:120];
    assign mid   = grid[71:64];

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            tick    <= 1'b0;
            lossOut <= 1'b0;
        end else begin
            tick    <= scroll;
            lossOut <= lossOut | hit | lossIn;
            if (frozen || cnt == TICK_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 12'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grid <= '0;
            sp   <= '0;
        end else if (scroll) begin
            grid[119:0] <= grid[127:8];
            if (sp == 3'd0) begin
                grid[127:120] <= newCol;
                sp            <= GAP_LOAD;
            end else begin
                grid[127:120] <= 8'h00;
                sp            <= sp - 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scoreTens <= 4'd0;
            scoreOnes <= 4'd0;
        end else if (score_en) begin
            {scoreTens, scoreOnes} <= bcd_inc_sat(scoreTens, scoreOnes);
        end
    end

endmodule

// File: tb/tb_pipe_scroll.sv
// Directed bench for pipe_scroll with TICK_MAX=3, BIRD_COL=2; u0 uses GAP=3, u1 uses GAP=0.
module tb_pipe_scroll;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset0, lossIn0, reset1, lossIn1;
    logic [7:0]   newCol0, birdRow0, newCol1, birdRow1;
    logic [127:0] grid0, grid1;
    logic [7:0]   right0, mid0, right1, mid1;
    logic         tick0, lossOut0, tick1, lossOut1;
    logic [3:0]   tens0, ones0, tens1, ones1;

    pipe_scroll #(.TICK_MAX(3), .BIRD_COL(2), .GAP(3)) u0 (
        .clock(clock), .reset(reset0), .lossIn(lossIn0), .newCol(newCol0), .birdRow(birdRow0),
        .grid(grid0), .right(right0), .mid(mid0), .tick(tick0), .lossOut(lossOut0),
        .scoreTens(tens0), .scoreOnes(ones0)
    );

    pipe_scroll #(.TICK_MAX(3), .BIRD_COL(2), .GAP(0)) u1 (
        .clock(clock), .reset(reset1), .lossIn(lossIn1), .newCol(newCol1), .birdRow(birdRow1),
        .grid(grid1), .right(right1), .mid(mid1), .tick(tick1), .lossOut(lossOut1),
        .scoreTens(tens1), .scoreOnes(ones1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Contents of the entry column after m scrolls from reset.
    function automatic logic [7:0] col15_after(input int m, input int gap, input logic [7:0] pat);
        logic [7:0] c;
        c = 8'h00;
        if (m >= 1 && ((m - 1) % (gap + 1)) == 0)
            c = pat;
        return c;
    endfunction

    function automatic logic [127:0] grid_after(input int k, input int gap, input logic [7:0] pat);
        logic [127:0] g;
        g = '0;
        for (int j = 0; j < 16; j++)
            g[8*j +: 8] = col15_after(k - (15 - j), gap, pat);
        return g;
    endfunction

    // Score counts scrolls whose pre-shift column 2 was nonzero, capped at 99, as BCD.
    function automatic logic [7:0] score_after(input int k, input int gap, input logic [7:0] pat);
        logic [127:0] g;
        int n;
        n = 0;
        for (int s = 1; s <= k; s++) begin
            g = grid_after(s - 1, gap, pat);
            if (g[23:16] != 8'h00 && n < 99)
                n++;
        end
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic scroll0(input int k);
        repeat (3) begin
            @(negedge clock);
            check("u0_tick_idle", tick0, 1'b0);
        end
        @(negedge clock);
        check("u0_tick", tick0, 1'b1);
        check("u0_grid", grid0, grid_after(k, 3, 8'hF8));
        check("u0_right", right0, col15_after(k, 3, 8'hF8));
        check("u0_mid", mid0, col15_after(k - 7, 3, 8'hF8));
        check("u0_score", {tens0, ones0}, score_after(k, 3, 8'hF8));
        check("u0_loss", lossOut0, 1'b0);
    endtask

    logic [127:0] held;

    initial begin
        reset0 = 1'b1; reset1 = 1'b1;
        lossIn0 = 1'b0; lossIn1 = 1'b0;
        newCol0 = 8'hF8; newCol1 = 8'h0F;
        birdRow0 = 8'h00; birdRow1 = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_grid", grid0, '0);
        check("rst_tick", tick0, 1'b0);
        check("rst_loss", lossOut0, 1'b0);
        check("rst_score", {tens0, ones0}, 8'h00);

        // Scrolls 1..18: pattern F8 every fourth column, score 1 once F8 leaves column 2.
        reset0 = 1'b0;
        for (int k = 1; k <= 18; k++)
            scroll0(k);
        check("col2_before_hit", grid0[23:16], 8'hF8);
        check("score_after_18", {tens0, ones0}, 8'h01);

        // Bird in the lit top row of column 2 -> loss and frozen field.
        birdRow0 = 8'h80;
        held = grid0;
        @(negedge clock);
        check("hit_loss", lossOut0, 1'b1);
        repeat (12) begin
            @(negedge clock);
            check("frozen_tick", tick0, 1'b0);
        end
        check("frozen_grid", grid0, held);
        check("frozen_score", {tens0, ones0}, 8'h01);
        check("frozen_loss", lossOut0, 1'b1);

        // Reset while frozen clears everything.
        reset0 = 1'b1;
        birdRow0 = 8'h00;
        @(negedge clock);
        check("rst2_grid", grid0, '0);
        check("rst2_loss", lossOut0, 1'b0);
        check("rst2_score", {tens0, ones0}, 8'h00);
        check("rst2_tick", tick0, 1'b0);

        // lossIn pulse coinciding with cnt==TICK_MAX blocks the scroll and latches loss.
        reset0 = 1'b0;
        repeat (3) @(negedge clock);
        lossIn0 = 1'b1;
        @(negedge clock);
        lossIn0 = 1'b0;
        check("lossin_tick", tick0, 1'b0);
        check("lossin_right", right0, 8'h00);
        check("lossin_loss", lossOut0, 1'b1);
        repeat (8) begin
            @(negedge clock);
            check("lossin_frozen_tick", tick0, 1'b0);
        end
        check("lossin_sticky", lossOut0, 1'b1);
        check("lossin_grid", grid0, '0);

        reset0 = 1'b1;
        @(negedge clock);
        check("rst3_loss", lossOut0, 1'b0);
        check("rst3_tick", tick0, 1'b0);
        reset0 = 1'b0;
        scroll0(1);
        scroll0(2);

        // GAP=0 instance: score reaches 98 at scroll 112 then saturates at 99.
        reset1 = 1'b0;
        for (int k = 1; k <= 114; k++) begin
            repeat (3) @(negedge clock);
            check("u1_tick_idle", tick1, 1'b0);
            @(negedge clock);
            check("u1_tick", tick1, 1'b1);
            check("u1_right", right1, 8'h0F);
            if (k == 112) check("u1_score_98", {tens1, ones1}, 8'h98);
            if (k == 113) check("u1_score_99", {tens1, ones1}, 8'h99);
            if (k == 114) check("u1_score_sat", {tens1, ones1}, 8'h99);
        end
        check("u1_grid_full", grid1, {16{8'h0F}});
        check("u1_mid", mid1, 8'h0F);
        check("u1_loss", lossOut1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
